demux_1x2_conductual: RTL and testbench

- Conductual 1:2 byte demultiplexer; the receive-side counterpart of the 2:1 interleaving mux.
- Takes a single interleaved byte stream (lane 0 byte, then lane 1 byte) with a valid qualifier.
- Rebuilds the two parallel lanes and presents both bytes together, one cycle after the pair completes.
- Flushes an orphaned lane-0 byte after a programmable idle gap so the lane phase re-aligns.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_idle_cnt.sv | 46 ++++
 rtl/demux_1x2_conductual.sv | 126 ++++++++++++
 tb/tb_demux_1x2_conductual.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 interleaved byte demultiplexer.
package demux_pkg;

    // Default lane width and idle-flush configuration.
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_FLUSH_CYCLES = 4;
    localparam int DEF_CNT_W        = 3;

    // Lane-phase state: EMPTY waits for a lane 0 byte, HALF holds one.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } demux_state_e;

endpackage : demux_pkg

// File: rtl/demux_idle_cnt.sv
// Saturating idle counter with clear/enable and a terminal-count flag.
// o_tc is high while the counter sits one step below FLUSH_CYCLES, so an
// enabled increment in that cycle is the one that "reaches" the threshold.
module demux_idle_cnt #(
    parameter int CNT_W        = 3,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int               TC_I     = (FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] TC_VAL   = TC_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic             FLUSH_EN = (FLUSH_CYCLES > 0);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear has priority; increment saturates instead of wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tc = FLUSH_EN & (r_cnt == TC_VAL);

endmodule : demux_idle_cnt

// File: rtl/demux_1x2_conductual.sv
// 1:2 demultiplexer: splits an interleaved lane0/lane1 byte stream back into
// two parallel lanes and presents each completed pair together. A lone lane 0
// byte is flushed out after an idle gap so the lane phase realigns.
module demux_1x2_conductual
    import demux_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] data_out_0,
    output logic             valid_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_1,
    output logic             lane_sel,
    output logic             flush_evt
);

    demux_state_e     r_state;
    demux_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_hold_0;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [WIDTH-1:0] r_data_0;
    logic [WIDTH-1:0] w_data_0_nxt;
    logic [WIDTH-1:0] r_data_1;
    logic [WIDTH-1:0] w_data_1_nxt;
    logic             r_valid_0;
    logic             w_valid_0_nxt;
    logic             r_valid_1;
    logic             w_valid_1_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_tc;

    // Idle gap tracking; only counts while a half pair is pending.
    demux_idle_cnt #(
        .CNT_W        (CNT_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_tc  (w_tc)
    );

    // Next-state and next-output decode; data_in is only looked at when valid.
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_0;
        w_data_0_nxt  = r_data_0;
        w_data_1_nxt  = r_data_1;
        w_valid_0_nxt = 1'b0;
        w_valid_1_nxt = 1'b0;
        w_flush_nxt   = 1'b0;
        w_cnt_clr     = 1'b1;
        w_cnt_en      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (valid_in) begin
                    w_hold_nxt  = data_in;
                    w_state_nxt = ST_HALF;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (valid_in) begin
                    // Pair complete: a late lane 1 byte beats a pending flush.
                    w_data_0_nxt  = r_hold_0;
                    w_data_1_nxt  = data_in;
                    w_valid_0_nxt = 1'b1;
                    w_valid_1_nxt = 1'b1;
                    w_state_nxt   = ST_EMPTY;
                end else if (w_tc) begin
                    // Idle gap expired: push out the orphan and realign.
                    w_data_0_nxt  = r_hold_0;
                    w_valid_0_nxt = 1'b1;
                    w_flush_nxt   = 1'b1;
                    w_state_nxt   = ST_EMPTY;
                end else begin
                    w_cnt_clr = 1'b0;
                    w_cnt_en  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, hold and output registers; reset discards any half pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_EMPTY;
            r_hold_0  <= {WIDTH{1'b0}};
            r_data_0  <= {WIDTH{1'b0}};
            r_data_1  <= {WIDTH{1'b0}};
            r_valid_0 <= 1'b0;
            r_valid_1 <= 1'b0;
            r_flush   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold_0  <= w_hold_nxt;
            r_data_0  <= w_data_0_nxt;
            r_data_1  <= w_data_1_nxt;
            r_valid_0 <= w_valid_0_nxt;
            r_valid_1 <= w_valid_1_nxt;
            r_flush   <= w_flush_nxt;
        end
    end

    assign data_out_0  = r_data_0;
    assign data_out_1  = r_data_1;
    assign valid_out_0 = r_valid_0;
    assign valid_out_1 = r_valid_1;
    assign flush_evt   = r_flush;
    assign lane_sel    = (r_state == ST_HALF);

endmodule : demux_1x2_conductual

// File: tb/tb_demux_1x2_conductual.sv
// Self-checking bench for demux_1x2_conductual (WIDTH=8, FLUSH_CYCLES=4).
module tb_demux_1x2_conductual;

    typedef struct packed {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       fl;
        logic       lane;
    } out_t;

    typedef struct {
        string      name;
        logic       vin;
        logic [7:0] din;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out_0;
    logic       valid_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_1;
    logic       lane_sel;
    logic       flush_evt;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t sb_q[$];
    vec_t vecs[$];

    demux_1x2_conductual dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out_0  (data_out_0),
        .valid_out_0 (valid_out_0),
        .data_out_1  (data_out_1),
        .valid_out_1 (valid_out_1),
        .lane_sel    (lane_sel),
        .flush_evt   (flush_evt)
    );

    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic out_t mk(logic v0, logic v1, logic [7:0] d0, logic [7:0] d1,
                                logic fl, logic lane);
        out_t o;
        o.v0 = v0; o.v1 = v1; o.d0 = d0; o.d1 = d1; o.fl = fl; o.lane = lane;
        return o;
    endfunction

    task automatic chk(string name, out_t exp);
        out_t act;
        act = mk(valid_out_0, valid_out_1, data_out_0, data_out_1, flush_evt, lane_sel);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got v0=%0b v1=%0b d0=%02h d1=%02h fl=%0b lane=%0b, expected v0=%0b v1=%0b d0=%02h d1=%02h fl=%0b lane=%0b",
                     name, act.v0, act.v1, act.d0, act.d1, act.fl, act.lane,
                     exp.v0, exp.v1, exp.d0, exp.d1, exp.fl, exp.lane);
        end
    endtask

    // Drive one cycle (called at negedge); expectation goes to the scoreboard
    // and is popped once the edge has produced the DUT's response.
    task automatic step(string name, logic vin, logic [7:0] din, out_t exp);
        valid_in = vin;
        data_in  = vin ? din : 8'($urandom);
        sb_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        chk(name, sb_q.pop_front());
    endtask

    task automatic add(string n, logic vin, logic [7:0] din, logic v0, logic v1,
                       logic [7:0] d0, logic [7:0] d1, logic fl, logic lane);
        vec_t v;
        v.name = n; v.vin = vin; v.din = din;
        v.exp  = mk(v0, v1, d0, d1, fl, lane);
        vecs.push_back(v);
    endtask

    initial begin
        // Expected outputs after each edge: v0 v1 d0 d1 fl lane.
        add("pair_a",     1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        add("pair_b",     1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
        add("pair_hold",  1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            add("stream_l0", 1'b1, 8'(2*k+1), 1'b0, 1'b0,
                (k == 0) ? 8'h11 : 8'(2*k-1), (k == 0) ? 8'h22 : 8'(2*k), 1'b0, 1'b1);
            add("stream_l1", 1'b1, 8'(2*k+2), 1'b1, 1'b1, 8'(2*k+1), 8'(2*k+2), 1'b0, 1'b0);
        end
        add("stream_end", 1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 8'h08, 1'b0, 1'b0);
        add("gap_l0",     1'b1, 8'h33, 1'b0, 1'b0, 8'h07, 8'h08, 1'b0, 1'b1);
        add("gap_idle1",  1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 8'h08, 1'b0, 1'b1);
        add("gap_idle2",  1'b0, 8'h00, 1'b0, 1'b0, 8'h07, 8'h08, 1'b0, 1'b1);
        add("gap_l1",     1'b1, 8'h44, 1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
        add("gap_hold",   1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0);
        add("fl_l0",      1'b1, 8'h55, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1);
        add("fl_idle1",   1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1);
        add("fl_idle2",   1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1);
        add("fl_idle3",   1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b1);
        add("fl_flush",   1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 8'h44, 1'b1, 1'b0);
        add("fl_after",   1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 8'h44, 1'b0, 1'b0);
        add("realign_l0", 1'b1, 8'h66, 1'b0, 1'b0, 8'h55, 8'h44, 1'b0, 1'b1);
        add("realign_l1", 1'b1, 8'h77, 1'b1, 1'b1, 8'h66, 8'h77, 1'b0, 1'b0);
        // Lane 1 arrives exactly when the fourth idle would flush: pair wins.
        add("race_l0",    1'b1, 8'h5A, 1'b0, 1'b0, 8'h66, 8'h77, 1'b0, 1'b1);
        add("race_idle1", 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 8'h77, 1'b0, 1'b1);
        add("race_idle2", 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 8'h77, 1'b0, 1'b1);
        add("race_idle3", 1'b0, 8'h00, 1'b0, 1'b0, 8'h66, 8'h77, 1'b0, 1'b1);
        add("race_l1",    1'b1, 8'h5B, 1'b1, 1'b1, 8'h5A, 8'h5B, 1'b0, 1'b0);
        add("race_hold",  1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0, 1'b0);
        add("mid_l0",     1'b1, 8'h88, 1'b0, 1'b0, 8'h5A, 8'h5B, 1'b0, 1'b1);

        // Power-on reset.
        reset    = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_init", mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        reset = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].name, vecs[i].vin, vecs[i].din, vecs[i].exp);
        end

        // Reset mid-pair (0x88 pending): outputs clear before any clock edge.
        #2;
        valid_in = 1'b1;
        data_in  = 8'hA5;
        reset    = 1'b0;
        #1;
        chk("reset_async", mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        chk("reset_held", mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0));
        valid_in = 1'b0;
        reset    = 1'b1;
        step("post_rst_l0", 1'b1, 8'h99, mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1));
        step("post_rst_l1", 1'b1, 8'hAA, mk(1'b1, 1'b1, 8'h99, 8'hAA, 1'b0, 1'b0));
        step("post_rst_hold", 1'b0, 8'h00, mk(1'b0, 1'b0, 8'h99, 8'hAA, 1'b0, 1'b0));
        step("post_rst_idle", 1'b0, 8'h00, mk(1'b0, 1'b0, 8'h99, 8'hAA, 1'b0, 1'b0));

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_demux_1x2_conductual
